abs_pipe: RTL and testbench

ABS_PIPE -- requirements
Module: abs_pipe

---
 rtl/abs_pkg.sv | 23 ++
 rtl/abs_lane.sv | 51 +++++
 rtl/abs_pipe.sv | 136 +++++++++++++
 tb/tb_abs_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/abs_pkg.sv
// Shared types and helpers for the absolute-value pipeline.
// Holds the per-beat operating mode and a max-positive helper that is
// used to build the saturation value for any lane width.
package abs_pkg;

  // Per-beat operating mode carried alongside the data.
  typedef enum logic [1:0] {
    MODE_TWOS   = 2'd0,  // two's-complement magnitude, saturating
    MODE_ONES   = 2'd1,  // one's-complement magnitude (legacy)
    MODE_BYPASS = 2'd2,  // pass the lane through untouched
    MODE_RSVD   = 2'd3   // reserved encoding, treated as MODE_TWOS
  } abs_mode_t;

  // Widest lane the helper below can describe.
  localparam int MAX_WIDTH = 64;

  // Largest positive value representable in a signed field of 'width' bits,
  // returned zero-extended to MAX_WIDTH bits.
  function automatic logic [MAX_WIDTH-1:0] max_pos(input int width);
    return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/abs_lane.sv
// Single-lane absolute-value datapath.
// Purely combinational: takes one signed lane and the beat mode and
// produces the magnitude plus a flag when the result had to saturate.
module abs_lane
  import abs_pkg::*;
#(
  parameter int pDATA_WIDTH = 32
) (
  input  logic [pDATA_WIDTH-1:0] x,
  input  abs_mode_t              mode,
  output logic [pDATA_WIDTH-1:0] y,
  output logic                   sat
);

  // Saturation value for this lane width, cut down from the wide helper.
  localparam logic [MAX_WIDTH-1:0]   MAX_POS_WIDE = max_pos(pDATA_WIDTH);
  localparam logic [pDATA_WIDTH-1:0] MAX_POS      = MAX_POS_WIDE[pDATA_WIDTH-1:0];

  logic is_neg;
  logic is_min;

  // The most-negative value is the only one whose negation does not fit.
  assign is_neg = x[pDATA_WIDTH-1];
  assign is_min = is_neg && (x[pDATA_WIDTH-2:0] == '0);

  // Select the lane result according to the beat mode.
  always_comb begin
    // NOTE: defaults first so every path assigns y and sat; otherwise latches are inferred.
    y   = x;
    sat = 1'b0;
    unique case (mode)
      MODE_ONES: begin
        if (is_neg) begin
          y = {1'b0, ~x[pDATA_WIDTH-2:0]};
        end
      end
      MODE_BYPASS: begin
        y = x;
      end
      MODE_TWOS, MODE_RSVD: begin
        if (is_min) begin
          y   = MAX_POS;
          sat = 1'b1;
        end else if (is_neg) begin
          y = -x;
        end
      end
    endcase
  end

endmodule

// File: rtl/abs_pipe.sv
// Two-stage valid/ready pipeline computing per-lane absolute values.
// S1 registers the incoming beat and its mode, the lane array works on S1,
// and S2 holds the finished results that drive the outputs. A saturating
// counter accumulates the number of saturated lanes leaving the block.
module abs_pipe
  import abs_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pCHANNELS   = 4,
  parameter int pCNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  abs_mode_t                        mode_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [pCHANNELS*pDATA_WIDTH-1:0] data_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [pCHANNELS*pDATA_WIDTH-1:0] abs_o,
  output logic [pCHANNELS-1:0]             sat_o,
  output logic [pCNT_WIDTH-1:0]            sat_cnt_o,
  input  logic                             sat_clr_i
);

  localparam int BUS_W = pCHANNELS * pDATA_WIDTH;
  // Popcount must hold values 0..pCHANNELS.
  localparam int PC_W  = $clog2(pCHANNELS + 1);
  // Counter plus popcount can never overflow this width.
  localparam int SUM_W = pCNT_WIDTH + PC_W;
  localparam logic [pCNT_WIDTH-1:0] CNT_MAX = '1;

  // Stage 1: captured beat.
  logic             s1_valid;
  logic [BUS_W-1:0] s1_data;
  abs_mode_t        s1_mode;

  // Stage 2 occupancy; its payload is abs_o / sat_o directly.
  logic             s2_valid;

  // Handshake helpers.
  logic             s1_advance;
  logic             in_xfer;
  logic             out_xfer;

  // Lane array results computed from stage 1.
  logic [BUS_W-1:0]     lane_y;
  logic [pCHANNELS-1:0] lane_sat;

  // Counter next-value path.
  logic [PC_W-1:0]       sat_pop;
  logic [SUM_W-1:0]      cnt_sum;
  logic [pCNT_WIDTH-1:0] cnt_next;

  // A stage may move forward when the stage after it is empty or emptying.
  assign s1_advance = !s2_valid || ready_i;
  assign ready_o    = !s1_valid || s1_advance;
  assign valid_o    = s2_valid;
  assign in_xfer    = valid_i && ready_o;
  assign out_xfer   = valid_o && ready_i;

  // One arithmetic lane per channel, all sharing the beat mode.
  for (genvar k = 0; k < pCHANNELS; k++) begin : g_lane
    abs_lane #(
      .pDATA_WIDTH(pDATA_WIDTH)
    ) u_lane (
      .x   (s1_data[k*pDATA_WIDTH +: pDATA_WIDTH]),
      .mode(s1_mode),
      .y   (lane_y[k*pDATA_WIDTH +: pDATA_WIDTH]),
      .sat (lane_sat[k])
    );
  end

  // Stage 1 occupancy: reload whenever the stage can accept a new beat.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (ready_o) begin
      s1_valid <= valid_i;
    end
  end

  // Stage 1 payload: captured only on an accepted input beat.
  always_ff @(posedge clk) begin
    // NOTE: payload needs no reset; s1_valid alone decides whether it is ever used.
    if (in_xfer) begin
      s1_data <= data_i;
      s1_mode <= mode_i;
    end
  end

  // Stage 2: take the computed lane results when stage 1 moves forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      abs_o    <= '0;
      sat_o    <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        abs_o <= lane_y;
        sat_o <= lane_sat;
      end
    end
  end

  // Count the saturated lanes in the beat currently presented at the output.
  always_comb begin
    sat_pop = '0;
    for (int k = 0; k < pCHANNELS; k++) begin
      sat_pop = sat_pop + PC_W'(sat_o[k]);
    end
  end

  // Add the popcount to the counter, sticking at all-ones instead of wrapping.
  always_comb begin
    cnt_sum  = SUM_W'(sat_cnt_o) + SUM_W'(sat_pop);
    cnt_next = cnt_sum[pCNT_WIDTH-1:0];
    if (cnt_sum > SUM_W'(CNT_MAX)) begin
      cnt_next = CNT_MAX;
    end
  end

  // Saturation event counter; a clear request overrides a same-cycle transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_o <= '0;
    end else if (sat_clr_i) begin
      sat_cnt_o <= '0;
    end else if (out_xfer) begin
      sat_cnt_o <= cnt_next;
    end
  end

endmodule

// File: tb/tb_abs_pipe.sv
// Self-checking bench for abs_pipe: 8-bit lanes, 4 channels.
// A second instance with a 4-bit counter exercises counter saturation/clear.
`timescale 1ns/1ps
module tb_abs_pipe;
  import abs_pkg::*;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int DW = W * C;

  typedef struct {
    logic [DW-1:0] abs;
    logic [C-1:0]  sat;
    int            acc_cyc;
  } exp_t;

  // Main instance signals.
  logic          clk;
  logic          rst_n;
  abs_mode_t     mode_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] abs_o;
  logic [C-1:0]  sat_o;
  logic [15:0]   sat_cnt_o;
  logic          sat_clr_i;

  // Small-counter instance signals.
  abs_mode_t     mode2;
  logic          valid2;
  logic          ready_o2;
  logic [DW-1:0] data2;
  logic          valid_o2;
  logic          ready2;
  logic [DW-1:0] abs_o2;
  logic [C-1:0]  sat_o2;
  logic [3:0]    cnt2;
  logic          clr2;

  // Bench bookkeeping.
  int            n_cmp;
  int            n_bad;
  exp_t          q[$];
  int            cyc;
  int            rdy_mode;
  int            n2;
  logic [15:0]   cnt_exp;
  logic [3:0]    cnt2_exp;
  logic          stall_prev;
  logic [DW-1:0] prev_abs;
  logic [C-1:0]  prev_sat;
  logic          last_acc;

  abs_pipe #(
    .pDATA_WIDTH(W),
    .pCHANNELS  (C),
    .pCNT_WIDTH (16)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode_i   (mode_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .abs_o    (abs_o),
    .sat_o    (sat_o),
    .sat_cnt_o(sat_cnt_o),
    .sat_clr_i(sat_clr_i)
  );

  abs_pipe #(
    .pDATA_WIDTH(W),
    .pCHANNELS  (C),
    .pCNT_WIDTH (4)
  ) u_dut_c4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode_i   (mode2),
    .valid_i  (valid2),
    .ready_o  (ready_o2),
    .data_i   (data2),
    .valid_o  (valid_o2),
    .ready_i  (ready2),
    .abs_o    (abs_o2),
    .sat_o    (sat_o2),
    .sat_cnt_o(cnt2),
    .sat_clr_i(clr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model built from signed integer arithmetic.
  function automatic exp_t model(input logic [DW-1:0] d, input abs_mode_t m);
    exp_t e;
    e.abs     = '0;
    e.sat     = '0;
    e.acc_cyc = 0;
    for (int k = 0; k < C; k++) begin
      int         v;
      logic [W-1:0] r;
      logic       s;
      v = int'($signed(d[k*W +: W]));
      s = 1'b0;
      if (v >= 0 || m == MODE_BYPASS) r = d[k*W +: W];
      else if (m == MODE_ONES)         r = W'(-v - 1);
      else if (v == -128) begin
        r = 8'd127;
        s = 1'b1;
      end else                         r = W'(-v);
      e.abs[k*W +: W] = r;
      e.sat[k]        = s;
    end
    return e;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle();
    exp_t e;
    int   inc;
    int   inc2;
    case (rdy_mode)
      0:       ready_i = 1'b1;
      1:       ready_i = (cyc % 3 == 0);
      default: ready_i = 1'b0;
    endcase
    #4;
    check("ready_o", 64'(ready_o), 64'(!(q.size() == 2 && !ready_i)));
    check("sat_cnt", 64'(sat_cnt_o), 64'(cnt_exp));
    if (q.size() == 0) check("idle_valid", 64'(valid_o), 64'd0);
    if (stall_prev) begin
      check("stall_valid", 64'(valid_o), 64'd1);
      check("stall_abs", 64'(abs_o), 64'(prev_abs));
      check("stall_sat", 64'(sat_o), 64'(prev_sat));
    end
    inc = 0;
    if (valid_o && ready_i && q.size() != 0) begin
      e = q.pop_front();
      check("abs", 64'(abs_o), 64'(e.abs));
      check("sat", 64'(sat_o), 64'(e.sat));
      if (rdy_mode == 0) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
      inc = $countones(e.sat);
    end
    if (sat_clr_i) cnt_exp = '0;
    else cnt_exp = (int'(cnt_exp) + inc > 65535) ? 16'hFFFF : 16'(int'(cnt_exp) + inc);
    stall_prev = valid_o && !ready_i;
    prev_abs   = abs_o;
    prev_sat   = sat_o;
    last_acc   = valid_i && ready_o;
    if (last_acc) begin
      e         = model(data_i, mode_i);
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    // Small-counter instance: every beat it sees is all lanes at -128.
    if (n2 == 0) check("c4_idle_valid", 64'(valid_o2), 64'd0);
    if (clr2) check("c4_clr_xfer", 64'(valid_o2), 64'd1);
    check("c4_sat_cnt", 64'(cnt2), 64'(cnt2_exp));
    inc2 = 0;
    if (valid_o2 && ready2 && n2 != 0) begin
      n2--;
      check("c4_abs", 64'(abs_o2), 64'h7F7F7F7F);
      check("c4_sat", 64'(sat_o2), 64'hF);
      inc2 = 4;
    end
    if (clr2) cnt2_exp = '0;
    else cnt2_exp = (int'(cnt2_exp) + inc2 > 15) ? 4'hF : 4'(int'(cnt2_exp) + inc2);
    if (valid2 && ready_o2) n2++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [DW-1:0] d, input abs_mode_t m);
    int n;
    data_i   = d;
    mode_i   = m;
    valid_i  = 1'b1;
    last_acc = 1'b0;
    n        = 0;
    while (!last_acc && n < 20) begin
      cycle();
      n++;
    end
    check("accept", 64'(last_acc), 64'd1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || n2 != 0) && n < 50) begin
      cycle();
      n++;
    end
    check("drain_main", 64'(q.size()), 64'd0);
    check("drain_c4", 64'(n2), 64'd0);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    cyc        = 0;
    rdy_mode   = 0;
    n2         = 0;
    cnt_exp    = '0;
    cnt2_exp   = '0;
    stall_prev = 1'b0;
    prev_abs   = '0;
    prev_sat   = '0;
    last_acc   = 1'b0;
    rst_n      = 1'b0;
    valid_i    = 1'b0;
    ready_i    = 1'b1;
    data_i     = '0;
    mode_i     = MODE_TWOS;
    sat_clr_i  = 1'b0;
    mode2      = MODE_TWOS;
    valid2     = 1'b0;
    data2      = 32'h80808080;
    ready2     = 1'b1;
    clr2       = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    check("rst_abs_o", 64'(abs_o), 64'd0);
    check("rst_sat_o", 64'(sat_o), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt_o), 64'd0);
    check("rst_c4_valid", 64'(valid_o2), 64'd0);
    rst_n = 1'b1;
    cycle();
    cycle();

    // Two's complement with one saturating lane: lanes {-5, 7, 0, -128}.
    send(32'h80_00_07_FB, MODE_TWOS);
    drain();
    check("ex_twos_cnt", 64'(sat_cnt_o), 64'd1);

    // One's complement: -5 -> 4, -128 -> 127 without saturation.
    send(32'h80_10_FF_FB, MODE_ONES);
    drain();
    check("ex_ones_cnt", 64'(sat_cnt_o), 64'd1);

    // Back-to-back beats, each with its own mode.
    send(32'h80_81_FF_FB, MODE_TWOS);
    send(32'h80_81_FF_FB, MODE_ONES);
    send(32'h80_81_FF_FB, MODE_BYPASS);
    send(32'h80_81_FF_FB, MODE_RSVD);
    drain();
    check("ex_modes_cnt", 64'(sat_cnt_o), 64'd3);

    // Ten beats under a 1,0,0 ready pattern.
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      send(DW'($urandom), abs_mode_t'($urandom_range(0, 3)));
    end
    drain();

    // Reset with two beats in flight.
    rdy_mode = 2;
    send(32'h80_80_80_80, MODE_TWOS);
    send(32'h01_02_03_04, MODE_BYPASS);
    check("inflight", 64'(q.size()), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_o", 64'(valid_o), 64'd0);
    check("mid_rst_sat_cnt", 64'(sat_cnt_o), 64'd0);
    check("mid_rst_ready_o", 64'(ready_o), 64'd1);
    check("mid_rst_sat_o", 64'(sat_o), 64'd0);
    q.delete();
    cnt_exp    = '0;
    cnt2_exp   = '0;
    n2         = 0;
    stall_prev = 1'b0;
    @(negedge clk);
    cyc++;
    rst_n    = 1'b1;
    rdy_mode = 0;
    cycle();
    send(32'hFB_80_01_7F, MODE_TWOS);
    drain();

    // 4-bit counter: five all-saturating beats stick at 15.
    valid2 = 1'b1;
    repeat (5) cycle();
    valid2 = 1'b0;
    drain();
    check("c4_cnt_stuck", 64'(cnt2), 64'd15);
    // Clear coinciding with a saturating output transfer.
    valid2 = 1'b1;
    cycle();
    valid2 = 1'b0;
    cycle();
    clr2 = 1'b1;
    cycle();
    clr2 = 1'b0;
    cycle();
    check("c4_cnt_cleared", 64'(cnt2), 64'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
